branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Supplies the fetch stage with a 2-bit direction prediction and a predicted target
//  for the current fetch PC; the fetch PC register consumes both at the next posedge.
//  Direct-mapped BTB of ENTRIES entries; each entry holds valid, tag, target and a
//  2-bit saturating counter. Trained by branch resolution from execute.
// PARAMETERS
//  ADDR_W   `INSTR_MEM_WIDTH  instruction address width
//  ENTRIES  16                BTB entries; power of two, >= 2
//  INDEX_W  $clog2(ENTRIES)   derived; index bits
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, synchronous, active-high
//  lookup_pc       in   ADDR_W   current fetch PC (fetch PC register output)
//  prediction      out  2        counter value; >1 means predict taken
//  addr_predicted  out  ADDR_W   predicted next PC
//  update_valid    in   1        resolved branch/jump this cycle
//  update_pc       in   ADDR_W   PC of the resolved instruction
//  update_taken    in   1        actual direction
//  update_target   in   ADDR_W   actual taken target
//  hit_count       out  32       perf: lookups that hit a valid entry
//  update_count    out  32       perf: accepted updates
// BEHAVIOUR
//  Addressing: idx = pc[INDEX_W+1:2]; tag = pc[ADDR_W-1:INDEX_W+2]; pc[1:0] ignored.
//  Lookup is combinational (0-cycle) from lookup_pc and registered table state.
//   hit  = valid[idx] && tag[idx]==tag(lookup_pc)
//   hit : prediction = ctr[idx]; addr_predicted = target[idx]
//   miss: prediction = 2'b01; addr_predicted = lookup_pc + 4 (mod 2^ADDR_W)
//  Update (posedge, update_valid=1), u = idx(update_pc):
//   entry hit, taken    : ctr = min(ctr+1,3); target <= update_target
//   entry hit, not taken: ctr = max(ctr-1,0); target unchanged
//   miss, taken         : allocate/overwrite: valid=1, tag, target, ctr=2'b10
//   miss, not taken     : no change (no allocation)
//  Counter saturates at 2'b11 and 2'b00; never wraps.
//  Same-cycle lookup and update of the same index: lookup sees pre-update state;
//   new state is visible from the following cycle (no bypass).
//  Aliasing: a different tag at the same index is a miss; allocation replaces it.
//  Reset: on the posedge with rst=1 all valid<=0, all ctr<=2'b01, targets/tags<=0,
//   hit_count<=0, update_count<=0; update_valid ignored during reset. Outputs are
//   therefore miss values (2'b01, lookup_pc+4) from the cycle after reset. Reset
//   mid-training discards all learned state.
//  hit_count increments each non-reset cycle with hit=1; update_count each non-reset
//   cycle with update_valid=1; both wrap at 2^32.
//  No stall input: fetch-side stall holds lookup_pc, so outputs hold while the table
//   is unchanged.
// TESTING
//  1. After reset, lookup_pc=0x0000_0040 -> prediction=01, addr_predicted=0x0000_0044,
//     hit_count=0.
//  2. Update pc=0x40 taken target=0x100, then lookup 0x40 -> prediction=10,
//     addr=0x100; hit_count increments.
//  3. Same PC: 3 further taken updates -> ctr 11, saturated; 4 not-taken updates ->
//     ctr 00, saturated; prediction then 00, addr=0x100.
//  4. Aliasing: train 0x40 taken, then update 0x40+4*ENTRIES taken target 0x200 ->
//     lookup 0x40 misses (01, 0x44); alias hits (10, 0x200).
//  5. Same cycle: lookup 0x40 and update 0x40 taken on a miss -> that cycle 01/0x44,
//     next cycle 10/target.
//  6. Mid-training rst pulse -> all lookups miss, counters cleared; not-taken update
//     on a miss allocates nothing.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational from the fetch PC and registered table state;
// training from execute is applied on the clock edge. Performance counters
// track hits and accepted updates.

`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif

module branch_predictor #(
  parameter int ADDR_W  = `INSTR_MEM_WIDTH,
  parameter int ENTRIES = 16,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic [1:0]        prediction,
  output logic [ADDR_W-1:0] addr_predicted,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  output logic [31:0]       hit_count,
  output logic [31:0]       update_count
);

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  logic              valid  [ENTRIES];
  logic [TAG_W-1:0]  tags   [ENTRIES];
  logic [ADDR_W-1:0] target [ENTRIES];
  logic [1:0]        ctr    [ENTRIES];

  logic [INDEX_W-1:0] lookup_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic [INDEX_W-1:0] update_idx;
  logic [TAG_W-1:0]   update_tag;
  logic               hit;
  logic               update_hit;

  // pc[1:0] is never part of index or tag: instructions are word aligned.
  assign lookup_idx = lookup_pc[INDEX_W+1:2];
  assign lookup_tag = lookup_pc[ADDR_W-1:INDEX_W+2];
  assign update_idx = update_pc[INDEX_W+1:2];
  assign update_tag = update_pc[ADDR_W-1:INDEX_W+2];

  assign hit        = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
  assign update_hit = valid[update_idx] && (tags[update_idx] == update_tag);

  // Combinational lookup; a miss predicts weakly not-taken, fall-through target.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    prediction     = CTR_RESET;
    addr_predicted = lookup_pc + ADDR_W'(4);
    if (hit) begin
      prediction     = ctr[lookup_idx];
      addr_predicted = target[lookup_idx];
    end
  end

  // Table training and perf counters; lookup sees pre-update state (no bypass).
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every read in this block on the
    // pre-edge value, so ordering of statements cannot change the result.
    if (rst) begin
      // NOTE: the whole table is reset because a reset must discard learned
      // state; tags/targets are cleared too so the array holds no stale data.
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tags[i]   <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_RESET;
      end
      hit_count    <= '0;
      update_count <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;

      if (update_valid) begin
        update_count <= update_count + 32'd1;
        if (update_hit) begin
          if (update_taken) begin
            if (ctr[update_idx] != 2'b11) ctr[update_idx] <= ctr[update_idx] + 2'd1;
            target[update_idx] <= update_target;
          end else begin
            if (ctr[update_idx] != 2'b00) ctr[update_idx] <= ctr[update_idx] - 2'd1;
          end
        end else if (update_taken) begin
          // Allocation replaces whatever entry (possibly an alias) lives here.
          valid[update_idx]  <= 1'b1;
          tags[update_idx]   <= update_tag;
          target[update_idx] <= update_target;
          ctr[update_idx]    <= CTR_ALLOC;
        end
      end
    end
  end

endmodule
